// File: rtl/traffic_pkg.sv
// Shared phase/lamp encodings and width helpers for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_MAIN_GO   = 2'd0,
    PH_MAIN_ATTN = 2'd1,
    PH_SIDE_GO   = 2'd2,
    PH_SIDE_ATTN = 2'd3
  } phase_e;

  localparam logic [1:0] ML_STOP      = 2'd0;
  localparam logic [1:0] ML_STOP_ATTN = 2'd1;
  localparam logic [1:0] ML_GO        = 2'd2;
  localparam logic [1:0] ML_GO_ATTN   = 2'd3;

  localparam logic [1:0] SL_GO        = 2'd0;
  localparam logic [1:0] SL_GO_ATTN   = 2'd1;
  localparam logic [1:0] SL_STOP      = 2'd2;
  localparam logic [1:0] SL_STOP_ATTN = 2'd3;

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_pick.sv
// Round-robin selector: first pending side after last_i, wrapping to the start.
module rr_pick
  import traffic_pkg::*;
#(
  parameter  int N_SIDE = 2,
  localparam int AS_W   = idx_w(N_SIDE)
) (
  input  logic [N_SIDE-1:0] req_i,
  input  logic [AS_W-1:0]   last_i,
  output logic [AS_W-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Upper slice (above last_i) has priority over the wrapped lower slice.
    for (int j = 0; j < N_SIDE; j++) begin
      if (!valid_o && req_i[j] && (j > int'(last_i))) begin
        valid_o = 1'b1;
        idx_o   = AS_W'(j);
      end
    end
    for (int j = 0; j < N_SIDE; j++) begin
      if (!valid_o && req_i[j] && (j <= int'(last_i))) begin
        valid_o = 1'b1;
        idx_o   = AS_W'(j);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Main/side-road phase controller: round-robin side service, congestion-extended
// main green, congestion cut of side green after a minimum, rest in main green.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int N_SIDE     = 2,
  parameter  int T_MAIN_GO  = 20,
  parameter  int T_MAIN_MAX = 40,
  parameter  int T_SIDE_GO  = 10,
  parameter  int T_SIDE_MIN = 4,
  parameter  int T_ATTN     = 3,
  localparam int AS_W       = idx_w(N_SIDE),
  localparam int CNT_W      = cnt_w(T_MAIN_MAX, T_SIDE_GO, T_ATTN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cong,
  input  logic [N_SIDE-1:0]   side_req,
  output logic [1:0]          main_state,
  output logic [2*N_SIDE-1:0] side_state,
  output logic [AS_W-1:0]     active_side,
  output logic [CNT_W-1:0]    phase_cnt,
  output logic [1:0]          phase_dbg
);

  localparam logic [CNT_W-1:0] ELAPSED_LIM  = CNT_W'(T_MAIN_MAX - 1);
  localparam logic [CNT_W-1:0] SIDE_CUT_CNT = CNT_W'(T_SIDE_GO - T_SIDE_MIN + 1);

  phase_e                phase_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      elapsed_q;
  logic [1:0]            main_q;
  logic [2*N_SIDE-1:0]   side_q;
  logic [AS_W-1:0]       active_q;
  logic [AS_W-1:0]       last_q;
  logic [N_SIDE-1:0]     pend_q;

  logic [N_SIDE-1:0]     pend_d;
  logic [N_SIDE-1:0]     act_mask;
  logic [N_SIDE-1:0]     pick_mask;
  logic [AS_W-1:0]       pick_idx;
  logic                  pick_valid;
  logic                  cnt_last;
  logic                  main_hold;
  logic                  side_cut;

  rr_pick #(.N_SIDE(N_SIDE)) u_pick (
    .req_i   (pend_q),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  function automatic logic [2*N_SIDE-1:0] side_lamps(input logic [AS_W-1:0] sel,
                                                      input logic [1:0]      lamp);
    logic [2*N_SIDE-1:0] r;
    r = '0;
    for (int i = 0; i < N_SIDE; i++) begin
      r[2*i +: 2] = (int'(sel) == i) ? lamp : SL_STOP;
    end
    return r;
  endfunction

  always_comb begin
    act_mask  = N_SIDE'(1) << active_q;
    pick_mask = N_SIDE'(1) << pick_idx;
    // The side being served cannot re-queue itself until main green returns.
    pend_d    = pend_q | (side_req & ~((phase_q != PH_MAIN_GO) ? act_mask : '0));
    cnt_last  = (cnt_q == CNT_W'(1));
    // elapsed_q counts completed cycles, so the current cycle is elapsed_q+1.
    main_hold = !pick_valid || (cong && (elapsed_q < ELAPSED_LIM));
    side_cut  = cnt_last || (cong && (cnt_q <= SIDE_CUT_CNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_MAIN_GO;
      cnt_q     <= CNT_W'(T_MAIN_GO);
      elapsed_q <= '0;
      main_q    <= ML_GO;
      side_q    <= {N_SIDE{SL_STOP}};
      active_q  <= '0;
      last_q    <= AS_W'(N_SIDE - 1);
      pend_q    <= '0;
    end else begin
      pend_q <= pend_d;
      case (phase_q)
        PH_MAIN_GO: begin
          if (elapsed_q != CNT_W'(T_MAIN_MAX)) elapsed_q <= elapsed_q + 1'b1;
          if (!cnt_last) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!main_hold) begin
            phase_q  <= PH_MAIN_ATTN;
            cnt_q    <= CNT_W'(T_ATTN);
            main_q   <= ML_GO_ATTN;
            side_q   <= side_lamps(pick_idx, SL_STOP_ATTN);
            active_q <= pick_idx;
            last_q   <= pick_idx;
            pend_q   <= pend_d & ~pick_mask;
          end
        end
        PH_MAIN_ATTN: begin
          if (cnt_last) begin
            phase_q <= PH_SIDE_GO;
            cnt_q   <= CNT_W'(T_SIDE_GO);
            main_q  <= ML_STOP;
            side_q  <= side_lamps(active_q, SL_GO);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PH_SIDE_GO: begin
          if (side_cut) begin
            phase_q <= PH_SIDE_ATTN;
            cnt_q   <= CNT_W'(T_ATTN);
            main_q  <= ML_STOP_ATTN;
            side_q  <= side_lamps(active_q, SL_GO_ATTN);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PH_SIDE_ATTN: begin
          if (cnt_last) begin
            phase_q   <= PH_MAIN_GO;
            cnt_q     <= CNT_W'(T_MAIN_GO);
            elapsed_q <= '0;
            main_q    <= ML_GO;
            side_q    <= {N_SIDE{SL_STOP}};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign main_state  = main_q;
  assign side_state  = side_q;
  assign active_side = active_q;
  assign phase_cnt   = cnt_q;
  assign phase_dbg   = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default parameters (2 sides, 20/40/10/4/3).
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cong;
  logic [1:0] side_req;
  logic [1:0] main_state;
  logic [3:0] side_state;
  logic [0:0] active_side;
  logic [5:0] phase_cnt;
  logic [1:0] phase_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int w;
  int n;
  logic [0:0] exp_q[$];

  typedef struct {
    int         cyc;
    logic       cong;
    logic [1:0] req;
    logic [1:0] main;
    logic [3:0] side;
    logic       act;
    int         cnt;
  } vec_t;

  vec_t tbl[13];

  traffic_phase_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cong        (cong),
    .side_req    (side_req),
    .main_state  (main_state),
    .side_state  (side_state),
    .active_side (active_side),
    .phase_cnt   (phase_cnt),
    .phase_dbg   (phase_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int m, input int s, input int a, input int c);
    chk({tag, "_main"}, int'(main_state), m);
    chk({tag, "_side"}, int'(side_state), s);
    chk({tag, "_act"},  int'(active_side), a);
    chk({tag, "_cnt"},  int'(phase_cnt), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After this returns the current cycle is cycle 1 (edge 1 is the next posedge).
  task automatic do_reset();
    rst_n    = 1'b0;
    cong     = 1'b0;
    side_req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,  1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 20};
    tbl[1]  = '{3,  1'b0, 2'b01, 2'd2, 4'b1010, 1'b0, 18};
    tbl[2]  = '{4,  1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 17};
    tbl[3]  = '{20, 1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 1};
    tbl[4]  = '{21, 1'b0, 2'b00, 2'd3, 4'b1011, 1'b0, 3};
    tbl[5]  = '{23, 1'b0, 2'b00, 2'd3, 4'b1011, 1'b0, 1};
    tbl[6]  = '{24, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 10};
    tbl[7]  = '{33, 1'b0, 2'b00, 2'd0, 4'b1000, 1'b0, 1};
    tbl[8]  = '{34, 1'b0, 2'b00, 2'd1, 4'b1001, 1'b0, 3};
    tbl[9]  = '{36, 1'b0, 2'b00, 2'd1, 4'b1001, 1'b0, 1};
    tbl[10] = '{37, 1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 20};
    tbl[11] = '{56, 1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 1};
    tbl[12] = '{60, 1'b0, 2'b00, 2'd2, 4'b1010, 1'b0, 1};

    // Idle: rest in main green, phase_cnt reaches 1 at cycle 20 and holds.
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      chk("idle_main", int'(main_state), 2);
      chk("idle_side", int'(side_state), 4'b1010);
      chk("idle_cnt",  int'(phase_cnt), (c <= 20) ? 21 - c : 1);
      tick();
    end

    // Single side-0 request, full phase walk from the vector table.
    do_reset();
    begin
      int p;
      p = 0;
      for (int c = 1; c <= 60; c++) begin
        cong     = 1'b0;
        side_req = 2'b00;
        if (p < 13 && tbl[p].cyc == c) begin
          cong     = tbl[p].cong;
          side_req = tbl[p].req;
          chk_out($sformatf("vec%0d", c), int'(tbl[p].main), int'(tbl[p].side),
                  int'(tbl[p].act), tbl[p].cnt);
          p++;
        end
        tick();
      end
      chk("vec_all_applied", p, 13);
    end

    // Request arriving on the MAIN_GO decision edge is seen one edge later.
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      side_req = (c == 20) ? 2'b10 : 2'b00;
      if (c == 21) begin
        chk("late_main", int'(main_state), 2);
        chk("late_cnt",  int'(phase_cnt), 1);
      end
      if (c == 22) chk_out("late_go", 3, 4'b1110, 1, 3);
      tick();
    end

    // Congestion held with a request pending: MAIN_GO lasts exactly 40 cycles.
    do_reset();
    cong = 1'b1;
    n = 0;
    while (main_state == 2'd2 && n < 200) begin
      side_req = (n == 1) ? 2'b01 : 2'b00;
      n++;
      tick();
    end
    side_req = 2'b00;
    chk("cong_main_len", n, 40);
    chk_out("cong_exit", 3, 4'b1011, 0, 3);
    cong = 1'b0;

    // Both sides requesting continuously: service order 0, 1, 0.
    do_reset();
    side_req = 2'b11;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int s = 0; s < 3; s++) begin
      w = 0;
      while (main_state != 2'd3 && w < 100) begin
        tick();
        w++;
      end
      chk("rr_reach_attn", int'(main_state), 3);
      chk("rr_active", int'(active_side), int'(exp_q.pop_front()));
      w = 0;
      while (main_state == 2'd3 && w < 10) begin
        tick();
        w++;
      end
    end
    side_req = 2'b00;

    // Re-requests from the served side during its phases do not queue a repeat.
    do_reset();
    for (int c = 1; c <= 62; c++) begin
      side_req = (c == 3 || c == 22 || c == 26 || c == 35) ? 2'b01 : 2'b00;
      if (c == 26) chk("norep_sidego", int'(main_state), 0);
      if (c == 37) chk_out("norep_back", 2, 4'b1010, 0, 20);
      if (c == 62) chk_out("norep_rest", 2, 4'b1010, 0, 1);
      tick();
    end
    side_req = 2'b00;

    // Congestion from the 2nd SIDE_GO cycle cuts side green to T_SIDE_MIN.
    do_reset();
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      side_req = (c == 3) ? 2'b01 : 2'b00;
      cong     = (c >= 25);
      if (main_state == 2'd0) n++;
      if (c == 27) chk_out("cut_last", 0, 4'b1000, 0, 7);
      if (c == 28) chk_out("cut_attn", 1, 4'b1001, 0, 3);
      tick();
    end
    chk("cut_side_len", n, 4);
    cong     = 1'b0;
    side_req = 2'b00;

    // Asynchronous reset in the middle of side 1's SIDE_GO.
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      side_req = (c == 3) ? 2'b10 : (c == 25) ? 2'b01 : 2'b00;
      if (c < 26) tick();
    end
    side_req = 2'b00;
    chk("arst_pre_main", int'(main_state), 0);
    chk("arst_pre_act",  int'(active_side), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 2, 4'b1010, 0, 20);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c == 22) chk_out("arst_cleared", 2, 4'b1010, 0, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised main/side-road traffic phase controller for N_SIDE side approaches sharing one main road. Round-robin service of latched side-road vehicle requests, a bounded congestion extension of main green, minimum side green before congestion cut-off, and rest-in-main-green when no side requests are pending. Sits between the detector/congestion inputs and the lamp drivers; one cycle is one second of real time.

## Interface
- N_SIDE, 2: number of side approaches, ≥1.
- T_MAIN_GO, 20: nominal main-green cycles, ≥1.
- T_MAIN_MAX, 40: maximum main-green cycles under congestion, ≥T_MAIN_GO.
- T_SIDE_GO, 10: side-green cycles, ≥1.
- T_SIDE_MIN, 4: side-green cycles served before congestion may cut it, 1..T_SIDE_GO.
- T_ATTN, 3: each attention phase, ≥1.
- clk  in  1  clock. One clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- cong  in  1  main-road congestion, level.
- side_req  in  N_SIDE  per-side vehicle detect, one-cycle pulse or level.
- main_state  out  2  0 STOP, 1 STOP-ATTN, 2 GO, 3 GO-ATTN.
- side_state  out  2*N_SIDE  per-side lamp, bits [2i+1:2i]: 0 GO, 1 GO-ATTN, 2 STOP, 3 STOP-ATTN.
- active_side  out  $clog2(N_SIDE) (min 1)  side selected for the current or most recent side phase.
- phase_cnt  out  CNT_W  cycles remaining in current phase; CNT_W = $clog2(max(T_MAIN_MAX,T_SIDE_GO,T_ATTN)+1).

## Operation
- Phases: MAIN_GO (main 2, active side 2), MAIN_ATTN (main 3, active side 3), SIDE_GO (main 0, active side 0), SIDE_ATTN (main 1, active side 1). Non-active sides always 2.
- req_pend[N_SIDE]: set by side_req[i]; requests for active_side ignored while in MAIN_ATTN, SIDE_GO, SIDE_ATTN. Cleared for active_side on entry to MAIN_ATTN.
- MAIN_GO: main_elapsed counts cycles in phase (saturating at T_MAIN_MAX). phase_cnt decrements to 1 then holds. At phase_cnt==1: if req_pend==0, hold (rest in main green); else if cong and main_elapsed<T_MAIN_MAX, hold; else go MAIN_ATTN, load T_ATTN, latch active_side = first pending side searching from last_served+1 with wrap, update last_served.
- MAIN_ATTN: at phase_cnt==1 go SIDE_GO, load T_SIDE_GO.
- SIDE_GO: if cong and cycles served ≥T_SIDE_MIN (T_SIDE_GO−phase_cnt+1 ≥ T_SIDE_MIN), or phase_cnt==1, go SIDE_ATTN, load T_ATTN.
- SIDE_ATTN: at phase_cnt==1 go MAIN_GO, load T_MAIN_GO, clear main_elapsed.
- Reset values: phase MAIN_GO, phase_cnt=T_MAIN_GO, main_state=2, all side_state=2, active_side=0, last_served=N_SIDE−1 (side 0 served first), req_pend=0, main_elapsed=0.
- Reset mid-phase: all outputs return to reset values immediately, pending requests discarded.

## Timing
- All outputs registered; phase and lamps change on the same edge that loads phase_cnt.
- Fixed phases last exactly their T cycles; MAIN_GO lasts ≥T_MAIN_GO and, with a request pending, ≤T_MAIN_MAX cycles.
- side_req sampled at edge k is visible in req_pend at k+1; a request arriving on the MAIN_GO decision edge is not seen by that decision.
- Simultaneous cong deassert and phase_cnt==1 in MAIN_GO with request pending: leave on that edge.

## Structure
- Package traffic_pkg: phase enum, main/side lamp encodings, CNT_W function.
- Sub-module rr_pick: combinational round-robin next-pending selector (req_pend, last_served -> index, valid).

## Test plan
- Reset, no requests, cong=0, 100 cycles -> main_state=2, side_state all 2, phase_cnt holds 1 from cycle 20.
- side_req[0] pulse at cycle 3, cong=0 (cycle 1 = first edge after rst_n release) -> MAIN_GO 1–20, MAIN_ATTN 21–23, SIDE_GO 24–33 (main 0, side0 0), SIDE_ATTN 34–36, MAIN_GO from 37; side1 stays 2.
- Request pending, cong held 1 -> MAIN_GO lasts exactly 40 cycles.
- Both sides requesting -> side0 served, then side1, then side0; side_req[0] during side0 SIDE_GO produces no repeat service.
- cong rises on 2nd cycle of SIDE_GO -> SIDE_GO lasts exactly 4 cycles.
- rst_n low mid SIDE_GO -> main_state=2, side_state all 2, active_side=0 without waiting for clk; pending requests cleared.
